mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Sits between the CPU control unit and memory_controller and is the only master on the memory bus.
- Accepts one load/store request at a time over a valid/ready handshake and holds the address, write data and write enable stable for a programmable number of cycles.
- Captures read data and returns a one-cycle response.
- Rejects unmapped addresses and writes to ROM before they reach the bus.

Parameters:
ADDR_WIDTH, 16, request/bus address width
DATA_WIDTH, 32, data width
WAIT_CYCLES, 1, cycles the bus is held per access (>=1); covers the RAM and negedge-I/O capture
ERR_CNT_WIDTH, 8, width of the saturating error counter

Ports:
clock  in  1  single system clock, rising-edge logic
reset  in  1  asynchronous, active-high reset
req_valid  in  1  CPU request present
req_ready  out  1  sequencer can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  store data
rsp_valid  out  1  one-cycle response strobe, no backpressure
rsp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
rsp_err  out  1  request rejected (unmapped address or ROM write)
err_count  out  ERR_CNT_WIDTH  saturating count of rejected requests
mem_address  out  ADDR_WIDTH  to memory_controller address
mem_data_in  out  DATA_WIDTH  to memory_controller data_in
mem_we  out  1  to memory_controller we
mem_data_out  in  DATA_WIDTH  from memory_controller data_out

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high.
- Reset values: every output is 0 (req_ready=0 while reset is asserted). State = IDLE; wait counter = 0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches req_addr, req_wdata and req_we.
  - Region decode runs on the latched request.
    - 0x0000-0x001F is ROM; a write there is an error.
    - 0x0020-0x003F is I/O.
    - 0x0800-0x0FFF is RAM.
    - Any other address is an error.
  - Error: go to RESP with error flagged; the bus is never driven with mem_we=1.
  - OK: go to ACCESS and load the counter with WAIT_CYCLES-1.
- ACCESS:
  - req_ready=0.
  - mem_address, mem_data_in and mem_we are driven from the latched request.
  - mem_we=req_we, held high for the whole of ACCESS on stores.
  - The counter decrements each cycle. On the edge where it reaches 0:
    - loads capture mem_data_out into rsp_rdata;
    - the state goes to RESP.
  - ACCESS always lasts exactly WAIT_CYCLES cycles.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_err is valid with rsp_valid; rsp_rdata is 0 unless this is a successful load.
  - The next state is IDLE unconditionally.
- Latency: handshake at edge N gives ACCESS in cycles N+1..N+W, rsp_valid in cycle N+W+1 and req_ready in cycle N+W+2. Error requests give rsp_valid in cycle N+1.
- Outside ACCESS:
  - mem_we=0.
  - mem_address and mem_data_in hold their last driven values, so the address does not toggle.
- rsp_err and rsp_rdata hold until the next RESP; only rsp_valid pulses.
- err_count increments on each RESP with an error and saturates at all ones; it is cleared only by reset.
- req_valid while req_ready=0 is ignored, not queued; the CPU holds the request.
- Reset mid-ACCESS: mem_we drops immediately (asynchronous) and no response is issued. A store in flight may or may not have committed; the CPU must reissue it.
- Request fields may change after the handshake with no effect.

Decomposition:
- Package mem_map_pkg:
  - ROM/IO/RAM base and limit constants;
  - region enum {REG_ROM, REG_IO, REG_RAM, REG_NONE} (aligned with memory_controller data_select encoding 0-3);
  - sequencer state enum.
- Sub-module addr_region_decode: combinational address-to-region decoder. memory_controller may reuse it later.

Test Plan:
- Store 0xDEADBEEF to 0x0800, then load 0x0800 (W=1):
  - the store gives mem_we=1 for one cycle and rsp_err=0, rsp_rdata=0;
  - the load gives rsp_rdata=0xDEADBEEF one cycle after ACCESS.
- Store 0x00000005 to 0x0020 with W=2:
  - mem_we high for exactly 2 cycles with mem_address=0x0020;
  - rsp_valid in cycle N+3; io_out=4'h5.
- Store to 0x0010 (ROM):
  - mem_we never asserted; rsp_valid in cycle N+1 with rsp_err=1;
  - err_count 0->1.
- Load from 0x0040, then from 0x1000:
  - both give rsp_err=1 and rsp_rdata=0; err_count=2.
- Drive 260 error requests: err_count saturates at 0xFF.
- Hold req_valid high for 3 back-to-back RAM loads (W=1):
  - handshakes at cycles 0, 3 and 6; exactly 3 rsp_valid pulses.
- Assert reset during ACCESS of a store:
  - mem_we=0 within the same cycle (asynchronous); no rsp_valid;
  - req_ready=1 on the first cycle after reset is released.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Memory map shared by the access sequencer and memory_controller:
// region boundaries, region encoding and sequencer state encoding.
package mem_map_pkg;

    localparam int unsigned ROM_BASE  = 32'h0000_0000;
    localparam int unsigned ROM_LIMIT = 32'h0000_001F;
    localparam int unsigned IO_BASE   = 32'h0000_0020;
    localparam int unsigned IO_LIMIT  = 32'h0000_003F;
    localparam int unsigned RAM_BASE  = 32'h0000_0800;
    localparam int unsigned RAM_LIMIT = 32'h0000_0FFF;

    // Encoding matches memory_controller data_select.
    typedef enum logic [1:0] {
        REG_ROM  = 2'd0,
        REG_IO   = 2'd1,
        REG_RAM  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_e;

    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned base,
                                      input int unsigned limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/addr_region_decode.sv
// Combinational word-address to memory-region decoder.
module addr_region_decode
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output region_e               region_o
);

    logic [31:0] addr_ext;

    always_comb begin
        addr_ext = 32'(addr_i);
        region_o = REG_NONE;
        if (in_range(addr_ext, ROM_BASE, ROM_LIMIT)) begin
            region_o = REG_ROM;
        end else if (in_range(addr_ext, IO_BASE, IO_LIMIT)) begin
            region_o = REG_IO;
        end else if (in_range(addr_ext, RAM_BASE, RAM_LIMIT)) begin
            region_o = REG_RAM;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Single bus master between the CPU control unit and memory_controller:
// one request at a time, bus held WAIT_CYCLES, one-cycle response.
module mem_access_sequencer
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WAIT_CYCLES   = 1,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]    mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_in,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_data_out
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    seq_state_e               state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ready_q;
    logic                     we_q;
    logic [ADDR_WIDTH-1:0]    mem_addr_q;
    logic [DATA_WIDTH-1:0]    mem_wdata_q;
    logic                     mem_we_q;
    logic                     rsp_valid_q;
    logic                     rsp_err_q;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_d;

    region_e req_region_c;
    logic    req_err_c;

    addr_region_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .addr_i   (req_addr),
        .region_o (req_region_c)
    );

    // Unmapped addresses and ROM stores never reach the bus.
    always_comb begin
        req_err_c = (req_region_c == REG_NONE) || ((req_region_c == REG_ROM) && req_we);
        err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        we_q    <= req_we;
                        if (req_err_c) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            err_cnt_q   <= err_cnt_d;
                        end else begin
                            state_q     <= ST_ACCESS;
                            cnt_q       <= CNT_LOAD;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_wdata;
                            mem_we_q    <= req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_RESP;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? '0 : mem_data_out;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign err_count   = err_cnt_q;
    assign mem_address = mem_addr_q;
    assign mem_data_in = mem_wdata_q;
    assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: two instances (WAIT_CYCLES 1 and 2), each
// attached to a simple word-addressed bus memory.
module tb_mem_access_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = 8;
    localparam int          ND = 2;
    localparam int          NT = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [ND-1:0]         req_valid, req_ready, req_we, rsp_valid, rsp_err, mem_we;
    logic [ND-1:0][AW-1:0] req_addr, mem_address;
    logic [ND-1:0][DW-1:0] req_wdata, rsp_rdata, mem_data_in, mem_data_out;
    logic [ND-1:0][EW-1:0] err_count;

    logic [DW-1:0] ref_mem [ND][4096];
    int            ref_errs [ND];
    int            tests = 0;
    int            fails = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        logic [DW-1:0] bus_mem [4096];

        mem_access_sequencer #(
            .ADDR_WIDTH    (AW),
            .DATA_WIDTH    (DW),
            .WAIT_CYCLES   (g + 1),
            .ERR_CNT_WIDTH (EW)
        ) u_dut (
            .clock        (clk),
            .reset        (rst),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g]),
            .err_count    (err_count[g]),
            .mem_address  (mem_address[g]),
            .mem_data_in  (mem_data_in[g]),
            .mem_we       (mem_we[g]),
            .mem_data_out (mem_data_out[g])
        );

        initial begin
            for (int i = 0; i < 4096; i++) bus_mem[i] = 32'hA500_0000 | 32'(i);
        end

        always @(posedge clk) begin
            if (mem_we[g]) bus_mem[mem_address[g][11:0]] = mem_data_in[g];
        end

        assign mem_data_out[g] = (mem_address[g] < 16'h1000) ? bus_mem[mem_address[g][11:0]]
                                                             : 32'hBAD0_BAD0;
    end

    typedef struct {
        int          d;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          wec;
        int          ecnt;
    } vec_t;

    vec_t tbl [NT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: region rules from the memory map, flat per-instance memory.
    function automatic bit ref_err(input bit we, input logic [15:0] a);
        int unsigned x = 32'(a);
        if (x <= 32'h1F) return we;
        if (x >= 32'h20 && x <= 32'h3F) return 1'b0;
        if (x >= 32'h800 && x <= 32'hFFF) return 1'b0;
        return 1'b1;
    endfunction

    task automatic ref_step(input int d, input bit we, input logic [15:0] a, input logic [31:0] wd,
                            output bit e, output logic [31:0] rd);
        e  = ref_err(we, a);
        rd = '0;
        if (e) begin
            if (ref_errs[d] < 255) ref_errs[d]++;
        end else if (we) begin
            ref_mem[d][a[11:0]] = wd;
        end else begin
            rd = ref_mem[d][a[11:0]];
        end
    endtask

    // Starts and ends just after a falling edge; latency counted in cycles after the handshake.
    task automatic apply(input int d, input bit we, input logic [15:0] a, input logic [31:0] wd,
                         output bit g_err, output logic [31:0] g_rd, output int g_lat,
                         output int g_wec, output logic [15:0] g_addr, output bit g_rdy);
        int guard = 0;
        g_err = 1'b0; g_rd = '0; g_lat = -1; g_wec = 0; g_addr = '0; g_rdy = 1'b0;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd;
        while (!req_ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready[d]) begin
            tests++;
            fails++;
            $display("FAIL hs_timeout: dut %0d req_ready stayed 0", d);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = 16'($urandom);
        req_wdata[d] = $urandom;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1) g_addr = mem_address[d];
            if (mem_we[d]) g_wec++;
            if (rsp_valid[d]) begin
                g_lat = k;
                g_err = rsp_err[d];
                g_rd  = rsp_rdata[d];
                @(negedge clk);
                g_rdy = req_ready[d];
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit          g_err, e_err, g_rdy;
        logic [31:0] g_rd, e_rd;
        logic [15:0] g_addr, a;
        int          g_lat, g_wec, d, nhs, npulse;
        int          hs [3];
        bit          we;
        logic [31:0] wd;

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < ND; i++) begin
            ref_errs[i] = 0;
            for (int j = 0; j < 4096; j++) ref_mem[i][j] = 32'hA500_0000 | 32'(j);
        end

        tbl[0]  = '{0, 1'b1, 16'h0800, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 2, 1, 0};
        tbl[1]  = '{0, 1'b0, 16'h0800, 32'h0000_0000, 1'b0, 32'hDEADBEEF, 2, 0, 0};
        tbl[2]  = '{1, 1'b1, 16'h0020, 32'h0000_0005, 1'b0, 32'h0000_0000, 3, 2, 0};
        tbl[3]  = '{1, 1'b0, 16'h0020, 32'h0000_0000, 1'b0, 32'h0000_0005, 3, 0, 0};
        tbl[4]  = '{0, 1'b1, 16'h0010, 32'h0000_1234, 1'b1, 32'h0000_0000, 1, 0, 1};
        tbl[5]  = '{0, 1'b0, 16'h0040, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0, 2};
        tbl[6]  = '{0, 1'b0, 16'h1000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0, 3};
        tbl[7]  = '{0, 1'b0, 16'h0005, 32'h0000_0000, 1'b0, 32'hA500_0005, 2, 0, 3};
        tbl[8]  = '{0, 1'b0, 16'h001F, 32'h0000_0000, 1'b0, 32'hA500_001F, 2, 0, 3};
        tbl[9]  = '{0, 1'b1, 16'h001F, 32'h0000_0077, 1'b1, 32'h0000_0000, 1, 0, 4};
        tbl[10] = '{0, 1'b0, 16'h003F, 32'h0000_0000, 1'b0, 32'hA500_003F, 2, 0, 4};
        tbl[11] = '{0, 1'b0, 16'h07FF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0, 5};
        tbl[12] = '{1, 1'b0, 16'h0FFF, 32'h0000_0000, 1'b0, 32'hA500_0FFF, 3, 0, 0};

        // Reset values
        repeat (2) @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            check($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'd0);
            check($sformatf("rst%0d_rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
            check($sformatf("rst%0d_mem_we", i), 32'(mem_we[i]), 32'd0);
            check($sformatf("rst%0d_err_count", i), 32'(err_count[i]), 32'd0);
            check($sformatf("rst%0d_mem_address", i), 32'(mem_address[i]), 32'd0);
            check($sformatf("rst%0d_rsp_rdata", i), rsp_rdata[i], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < ND; i++) check($sformatf("post_rst%0d_ready", i), 32'(req_ready[i]), 32'd1);

        // Directed vectors
        for (int i = 0; i < NT; i++) begin
            apply(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, g_err, g_rd, g_lat, g_wec, g_addr, g_rdy);
            ref_step(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, e_err, e_rd);
            check($sformatf("vec%0d_err", i), 32'(g_err), 32'(tbl[i].err));
            check($sformatf("vec%0d_rdata", i), g_rd, tbl[i].rdata);
            check($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d_we_cycles", i), 32'(g_wec), 32'(tbl[i].wec));
            check($sformatf("vec%0d_err_count", i), 32'(err_count[tbl[i].d]), 32'(tbl[i].ecnt));
            check($sformatf("vec%0d_ready_after", i), 32'(g_rdy), 32'd1);
            if (!tbl[i].err) check($sformatf("vec%0d_bus_addr", i), 32'(g_addr), 32'(tbl[i].addr));
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            d  = int'($urandom_range(0, 1));
            we = 1'($urandom);
            wd = $urandom;
            case ($urandom_range(0, 3))
                0:       a = 16'h0800 + 16'($urandom_range(0, 15));
                1:       a = 16'h0020 + 16'($urandom_range(0, 31));
                2:       a = 16'($urandom_range(0, 31));
                default: a = 16'($urandom);
            endcase
            apply(d, we, a, wd, g_err, g_rd, g_lat, g_wec, g_addr, g_rdy);
            ref_step(d, we, a, wd, e_err, e_rd);
            check($sformatf("rnd%0d_err", n), 32'(g_err), 32'(e_err));
            check($sformatf("rnd%0d_rdata", n), g_rd, e_rd);
            check($sformatf("rnd%0d_latency", n), 32'(g_lat), e_err ? 32'd1 : 32'(d + 2));
            check($sformatf("rnd%0d_we_cycles", n), 32'(g_wec), (!e_err && we) ? 32'(d + 1) : 32'd0);
            check($sformatf("rnd%0d_err_count", n), 32'(err_count[d]), 32'(ref_errs[d]));
            check($sformatf("rnd%0d_ready_after", n), 32'(g_rdy), 32'd1);
            if (!e_err) check($sformatf("rnd%0d_bus_addr", n), 32'(g_addr), 32'(a));
        end

        // Error counter saturation; rsp_err holds after the strobe
        for (int n = 0; n < 260; n++) begin
            apply(0, 1'b0, 16'h2000, 32'h0, g_err, g_rd, g_lat, g_wec, g_addr, g_rdy);
            ref_step(0, 1'b0, 16'h2000, 32'h0, e_err, e_rd);
        end
        check("sat_err_count", 32'(err_count[0]), 32'h0000_00FF);
        check("sat_rsp_err_hold", 32'(rsp_err[0]), 32'd1);
        check("sat_rsp_valid_low", 32'(rsp_valid[0]), 32'd0);
        apply(0, 1'b0, 16'h0801, 32'h0, g_err, g_rd, g_lat, g_wec, g_addr, g_rdy);
        ref_step(0, 1'b0, 16'h0801, 32'h0, e_err, e_rd);
        check("sat_ok_err", 32'(g_err), 32'd0);
        check("sat_ok_rdata", g_rd, e_rd);
        check("sat_stays", 32'(err_count[0]), 32'h0000_00FF);

        // Back-to-back loads with req_valid held high (W=1)
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0800;
        nhs = 0; npulse = 0;
        for (int c = 0; c < 12; c++) begin
            if (rsp_valid[0]) begin
                npulse++;
                check("b2b_rdata", rsp_rdata[0], ref_mem[0][12'h800]);
            end
            if (req_valid[0] && req_ready[0] && nhs < 3) begin
                hs[nhs] = c;
                nhs++;
            end
            @(negedge clk);
            if (nhs == 3) req_valid[0] = 1'b0;
        end
        check("b2b_handshakes", 32'(nhs), 32'd3);
        check("b2b_hs0", 32'(hs[0]), 32'd0);
        check("b2b_hs1", 32'(hs[1]), 32'd3);
        check("b2b_hs2", 32'(hs[2]), 32'd6);
        check("b2b_pulses", 32'(npulse), 32'd3);

        // Reset during the ACCESS phase of a store (W=2)
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 16'h0900; req_wdata[1] = 32'hCAFE_0001;
        check("rstacc_pre_ready", 32'(req_ready[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rstacc_pre_we", 32'(mem_we[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstacc_async_we", 32'(mem_we[1]), 32'd0);
        check("rstacc_ready", 32'(req_ready[1]), 32'd0);
        npulse = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[1]) npulse++;
        end
        rst = 1'b0;
        for (int i = 0; i < ND; i++) ref_errs[i] = 0;
        @(posedge clk);
        #1;
        check("rstacc_release_ready", 32'(req_ready[1]), 32'd1);
        if (rsp_valid[1]) npulse++;
        check("rstacc_no_rsp", 32'(npulse), 32'd0);
        check("rstacc_err_count", 32'(err_count[0]), 32'd0);
        @(negedge clk);
        apply(1, 1'b1, 16'h0901, 32'h1357_9BDF, g_err, g_rd, g_lat, g_wec, g_addr, g_rdy);
        ref_step(1, 1'b1, 16'h0901, 32'h1357_9BDF, e_err, e_rd);
        apply(1, 1'b0, 16'h0901, 32'h0, g_err, g_rd, g_lat, g_wec, g_addr, g_rdy);
        ref_step(1, 1'b0, 16'h0901, 32'h0, e_err, e_rd);
        check("rstacc_resume_rdata", g_rd, e_rd);
        check("rstacc_resume_latency", 32'(g_lat), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
